// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
// Runs request-to-send, shifts one byte on device clocks, checks the ACK.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clock,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_drive_low,
    output logic       ps2_data_drive_low
);

    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START,
        XFER,
        ACK,
        RELEASE,
        DONE,
        ERR
    } state_t;

    state_t        state, state_n;
    logic [IW-1:0] icnt, icnt_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic [3:0]    slot, slot_n;
    logic [7:0]    data_q, data_n;
    logic          parity_q, parity_n;
    logic [2:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          clk_s, data_s, fall, timeout;
    logic [15:0]   drv_bits;
    logic          clk_low_n, data_low_n;

    // Lines idle high, so the synchronizers reset high to avoid a false fall.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            clk_sync  <= 3'b111;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[1:0], ps2_clk_in};
            data_sync <= {data_sync[0], ps2_data_in};
        end
    end

    assign clk_s   = clk_sync[1];
    assign data_s  = data_sync[1];
    assign fall    = clk_sync[2] & ~clk_sync[1];
    assign timeout = (tcnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state              <= IDLE;
            icnt               <= '0;
            tcnt               <= '0;
            slot               <= '0;
            data_q             <= '0;
            parity_q           <= 1'b0;
            ps2_clk_drive_low  <= 1'b0;
            ps2_data_drive_low <= 1'b0;
            tx_busy            <= 1'b0;
            tx_done            <= 1'b0;
            tx_err             <= 1'b0;
        end else begin
            state              <= state_n;
            icnt               <= icnt_n;
            tcnt               <= tcnt_n;
            slot               <= slot_n;
            data_q             <= data_n;
            parity_q           <= parity_n;
            ps2_clk_drive_low  <= clk_low_n;
            ps2_data_drive_low <= data_low_n;
            tx_busy            <= (state_n != IDLE);
            tx_done            <= (state_n == DONE);
            tx_err             <= (state_n == ERR);
        end
    end

    always_comb begin
        state_n  = state;
        icnt_n   = icnt;
        tcnt_n   = tcnt;
        slot_n   = slot;
        data_n   = data_q;
        parity_n = parity_q;
        case (state)
            IDLE: begin
                icnt_n = '0;
                tcnt_n = '0;
                slot_n = '0;
                if (tx_start) begin
                    data_n   = tx_data;
                    parity_n = ~^tx_data;
                    state_n  = INHIBIT;
                end
            end
            INHIBIT: begin
                if (icnt == IW'(INHIBIT_CYCLES - 1))
                    state_n = START;
                else
                    icnt_n = icnt + 1'b1;
            end
            START: begin
                tcnt_n  = '0;
                slot_n  = '0;
                state_n = XFER;
            end
            XFER: begin
                if (fall) begin
                    tcnt_n = '0;
                    slot_n = slot + 4'd1;
                    if (slot == 4'd9)
                        state_n = ACK;
                end else if (timeout) begin
                    state_n = ERR;
                end else begin
                    tcnt_n = tcnt + 1'b1;
                end
            end
            ACK: begin
                if (fall) begin
                    tcnt_n  = '0;
                    state_n = data_s ? ERR : RELEASE;
                end else if (timeout) begin
                    state_n = ERR;
                end else begin
                    tcnt_n = tcnt + 1'b1;
                end
            end
            RELEASE: begin
                if (clk_s && data_s)
                    state_n = DONE;
                else if (timeout)
                    state_n = ERR;
                else if (fall)
                    tcnt_n = '0;
                else
                    tcnt_n = tcnt + 1'b1;
            end
            DONE:    state_n = IDLE;
            ERR:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Slot 0 is the start bit; slots past the parity leave data released.
    assign drv_bits = {6'b0, ~parity_n, ~data_n, 1'b1};

    always_comb begin
        clk_low_n  = (state_n == INHIBIT) || (state_n == START);
        data_low_n = (state_n == START) ||
                     ((state_n == XFER) && drv_bits[slot_n]);
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: randomized bench with a behavioural PS/2 device model.
// Frames are predicted from byte values, not from the RTL structure.
module tb_ps2_host_tx;

    localparam int INH  = 20;
    localparam int TMO  = 500;
    localparam int HALF = 30;

    logic       clock;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy, tx_done, tx_err;
    logic       ps2_clk_in, ps2_data_in;
    logic       ps2_clk_drive_low, ps2_data_drive_low;
    logic       dev_clk_low, dev_data_low;

    int passed = 0;
    int total  = 0;
    int cyc = 0;
    int done_cnt = 0, err_cnt = 0, both_cnt = 0;
    int inh_cnt = 0, start_cnt = 0, err_cyc = 0;
    logic busy_after_done = 1'b1;
    logic prev_done = 1'b0;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock             (clock),
        .rst               (rst),
        .tx_data           (tx_data),
        .tx_start          (tx_start),
        .tx_busy           (tx_busy),
        .tx_done           (tx_done),
        .tx_err            (tx_err),
        .ps2_clk_in        (ps2_clk_in),
        .ps2_data_in       (ps2_data_in),
        .ps2_clk_drive_low (ps2_clk_drive_low),
        .ps2_data_drive_low(ps2_data_drive_low)
    );

    // Open-drain bus: either side pulling low wins.
    assign ps2_clk_in  = ~(ps2_clk_drive_low | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_drive_low | dev_data_low);

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (tx_done) done_cnt++;
        if (tx_err) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (tx_done && tx_err) both_cnt++;
        if (ps2_clk_drive_low && !ps2_data_drive_low) inh_cnt++;
        if (ps2_clk_drive_low && ps2_data_drive_low) start_cnt++;
        if (prev_done) busy_after_done = tx_busy;
        prev_done = tx_done;
    end

    function automatic logic [10:0] frame_of(input logic [7:0] b);
        logic [10:0] f;
        int ones;
        ones = 0;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            f[i+1] = b[i];
            ones += int'(b[i]);
        end
        f[9]  = (ones % 2 == 0) ? 1'b1 : 1'b0;
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic request(input logic [7:0] b);
        @(negedge clock);
        tx_data  = b;
        tx_start = 1'b1;
        @(negedge clock);
        tx_start = 1'b0;
    endtask

    // Device: samples on its rising edges, then drives the ACK bit.
    task automatic device_run(input int nfalls, input bit ack_low,
                              output logic [10:0] samp,
                              output int fall_cyc, output bit ok);
        int n;
        samp = 'x;
        fall_cyc = 0;
        ok = 1'b0;
        n = 0;
        while (n < 300 &&
               !(ps2_clk_drive_low == 1'b0 && ps2_data_drive_low == 1'b1)) begin
            @(negedge clock);
            n++;
        end
        if (n >= 300) return;
        ok = 1'b1;
        repeat (5) @(negedge clock);
        samp[0] = ps2_data_in;
        for (int i = 1; i <= 10 && i <= nfalls; i++) begin
            dev_clk_low = 1'b1;
            fall_cyc = cyc;
            repeat (HALF) @(negedge clock);
            dev_clk_low = 1'b0;
            repeat (2) @(negedge clock);
            samp[i] = ps2_data_in;
            repeat (HALF - 2) @(negedge clock);
        end
        if (nfalls < 11) return;
        dev_data_low = ack_low;
        repeat (HALF / 2) @(negedge clock);
        dev_clk_low = 1'b1;
        fall_cyc = cyc;
        repeat (HALF) @(negedge clock);
        dev_clk_low = 1'b0;
        repeat (5) @(negedge clock);
        dev_data_low = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        int n;
        n = 0;
        while (tx_busy && n < 3000) begin
            @(negedge clock);
            n++;
        end
        ok = !tx_busy;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_reset;
        @(negedge clock);
        total++;
        if ({ps2_clk_drive_low, ps2_data_drive_low, tx_busy, tx_done, tx_err} !== 5'b0)
            $display("FAIL reset_outputs: got %b expected 00000",
                     {ps2_clk_drive_low, ps2_data_drive_low, tx_busy, tx_done, tx_err});
        else passed++;
        rst = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    task automatic test_led_cmd;
        logic [10:0] samp;
        int fc, i0, s0, d0, e0;
        bit ok, idle;
        i0 = inh_cnt; s0 = start_cnt; d0 = done_cnt; e0 = err_cnt;
        request(8'hED);
        total++;
        if (tx_busy !== 1'b1)
            $display("FAIL ed_busy_after_accept: got %b expected 1", tx_busy);
        else passed++;
        device_run(11, 1'b1, samp, fc, ok);
        wait_idle(idle);
        total++;
        if (inh_cnt - i0 !== INH)
            $display("FAIL ed_inhibit_len: got %0d expected %0d", inh_cnt - i0, INH);
        else passed++;
        total++;
        if (start_cnt - s0 !== 1)
            $display("FAIL ed_start_len: got %0d expected 1", start_cnt - s0);
        else passed++;
        total++;
        if (samp !== frame_of(8'hED))
            $display("FAIL ed_frame: got %b expected %b", samp, frame_of(8'hED));
        else passed++;
        total++;
        if ({idle, done_cnt - d0, err_cnt - e0} !== {1'b1, 32'd1, 32'd0})
            $display("FAIL ed_outcome: got idle=%b done=%0d err=%0d expected 1/1/0",
                     idle, done_cnt - d0, err_cnt - e0);
        else passed++;
        total++;
        if (busy_after_done !== 1'b0)
            $display("FAIL ed_busy_after_done: got %b expected 0", busy_after_done);
        else passed++;
    endtask

    task automatic test_enable_cmd;
        logic [10:0] samp;
        int fc, d0;
        bit ok, idle;
        d0 = done_cnt;
        request(8'hF4);
        device_run(11, 1'b1, samp, fc, ok);
        wait_idle(idle);
        total++;
        if (samp !== frame_of(8'hF4))
            $display("FAIL f4_frame: got %b expected %b", samp, frame_of(8'hF4));
        else passed++;
        total++;
        if (done_cnt - d0 !== 1)
            $display("FAIL f4_done: got %0d expected 1", done_cnt - d0);
        else passed++;
    endtask

    task automatic test_nack;
        logic [10:0] samp;
        int fc, d0, e0;
        bit ok, idle;
        d0 = done_cnt; e0 = err_cnt;
        request(8'h00);
        device_run(11, 1'b0, samp, fc, ok);
        wait_idle(idle);
        total++;
        if (samp !== frame_of(8'h00))
            $display("FAIL nack_frame: got %b expected %b", samp, frame_of(8'h00));
        else passed++;
        total++;
        if ({done_cnt - d0, err_cnt - e0} !== {32'd0, 32'd1})
            $display("FAIL nack_outcome: got done=%0d err=%0d expected 0/1",
                     done_cnt - d0, err_cnt - e0);
        else passed++;
        total++;
        if ({ps2_clk_drive_low, ps2_data_drive_low, tx_busy} !== 3'b000)
            $display("FAIL nack_released: got %b expected 000",
                     {ps2_clk_drive_low, ps2_data_drive_low, tx_busy});
        else passed++;
    endtask

    task automatic test_timeout;
        logic [10:0] samp;
        int fc, e0;
        bit ok, idle;
        e0 = err_cnt;
        request(8'hA5);
        device_run(4, 1'b1, samp, fc, ok);
        wait_idle(idle);
        total++;
        if (err_cnt - e0 !== 1)
            $display("FAIL timeout_err: got %0d expected 1", err_cnt - e0);
        else passed++;
        // fall reaches the counter 3 cycles after the line drops
        total++;
        if (err_cyc - fc !== TMO + 3)
            $display("FAIL timeout_delay: got %0d expected %0d", err_cyc - fc, TMO + 3);
        else passed++;
        total++;
        if ({ps2_clk_drive_low, ps2_data_drive_low, tx_busy} !== 3'b000)
            $display("FAIL timeout_released: got %b expected 000",
                     {ps2_clk_drive_low, ps2_data_drive_low, tx_busy});
        else passed++;
    endtask

    task automatic test_back_to_back;
        logic [10:0] samp;
        int fc, d0;
        bit ok, idle;
        logic busy_at_pulse;
        d0 = done_cnt;
        request(8'h3C);
        fork
            device_run(11, 1'b1, samp, fc, ok);
            begin
                repeat (150) @(negedge clock);
                busy_at_pulse = tx_busy;
                tx_data  = 8'hFF;
                tx_start = 1'b1;
                @(negedge clock);
                tx_start = 1'b0;
            end
        join
        wait_idle(idle);
        total++;
        if ({busy_at_pulse, samp} !== {1'b1, frame_of(8'h3C)})
            $display("FAIL ignore_frame: got busy=%b %b expected 1 %b",
                     busy_at_pulse, samp, frame_of(8'h3C));
        else passed++;
        repeat (50) @(negedge clock);
        total++;
        if ({done_cnt - d0, tx_busy, ps2_clk_drive_low} !== {32'd1, 2'b00})
            $display("FAIL ignore_no_queue: got done=%0d busy=%b clk=%b expected 1/0/0",
                     done_cnt - d0, tx_busy, ps2_clk_drive_low);
        else passed++;
        // a device already holding the clock low at request time
        dev_clk_low = 1'b1;
        request(8'hFF);
        repeat (8) @(negedge clock);
        dev_clk_low = 1'b0;
        device_run(11, 1'b1, samp, fc, ok);
        wait_idle(idle);
        total++;
        if ({samp, done_cnt - d0} !== {frame_of(8'hFF), 32'd2})
            $display("FAIL ff_frame: got %b done=%0d expected %b done=2",
                     samp, done_cnt - d0, frame_of(8'hFF));
        else passed++;
    endtask

    task automatic test_reset_mid;
        logic [10:0] samp;
        int fc, d0;
        bit ok, idle;
        request(8'hED);
        device_run(6, 1'b1, samp, fc, ok);
        d0 = done_cnt;
        total++;
        if (tx_busy !== 1'b1)
            $display("FAIL midrst_busy_before: got %b expected 1", tx_busy);
        else passed++;
        rst = 1'b1;
        #1;
        total++;
        if ({ps2_clk_drive_low, ps2_data_drive_low, tx_busy, tx_done, tx_err} !== 5'b0)
            $display("FAIL midrst_outputs: got %b expected 00000",
                     {ps2_clk_drive_low, ps2_data_drive_low, tx_busy, tx_done, tx_err});
        else passed++;
        repeat (3) @(negedge clock);
        rst = 1'b0;
        repeat (5) @(negedge clock);
        total++;
        if (done_cnt - d0 !== 0)
            $display("FAIL midrst_no_done: got %0d expected 0", done_cnt - d0);
        else passed++;
        d0 = done_cnt;
        request(8'hED);
        device_run(11, 1'b1, samp, fc, ok);
        wait_idle(idle);
        total++;
        if ({samp, done_cnt - d0} !== {frame_of(8'hED), 32'd1})
            $display("FAIL midrst_retry: got %b done=%0d expected %b done=1",
                     samp, done_cnt - d0, frame_of(8'hED));
        else passed++;
    endtask

    task automatic test_random;
        logic [10:0] samp;
        logic [7:0] b;
        int fc, d0, e0;
        bit ok, idle, ack;
        for (int k = 0; k < 5; k++) begin
            b   = 8'($urandom_range(0, 255));
            ack = ($urandom_range(0, 3) != 0);
            d0 = done_cnt; e0 = err_cnt;
            request(b);
            device_run(11, ack, samp, fc, ok);
            wait_idle(idle);
            total++;
            if (samp !== frame_of(b))
                $display("FAIL rand_frame %h: got %b expected %b", b, samp, frame_of(b));
            else passed++;
            total++;
            if ({done_cnt - d0, err_cnt - e0} !== {32'(ack), 32'(!ack)})
                $display("FAIL rand_outcome %h ack=%b: got done=%0d err=%0d",
                         b, ack, done_cnt - d0, err_cnt - e0);
            else passed++;
        end
    endtask

    initial begin
        rst          = 1'b1;
        tx_start     = 1'b0;
        tx_data      = 8'h5A;
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        test_reset();
        test_led_cmd();
        test_enable_cmd();
        test_nack();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_random();
        total++;
        if (both_cnt !== 0)
            $display("FAIL done_err_overlap: got %0d expected 0", both_cnt);
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. Sends one command byte to the keyboard, e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset.
- Sits beside the keyboard receive path and shares the PS2_CLK/PS2_DATA open-drain pads. Drives only "pull low" enables; the pad wrapper turns an enable into a low drive and a deassertion into high-Z.
- Performs the full host request-to-send sequence, including the clock inhibit, the 11 device-clocked bit slots and the device ACK check.
- Reports completion or error to the command issuer.

Parameters:
- INHIBIT_CYCLES, 12000: clock-low hold before the start bit (120 us at 100 MHz).
- TIMEOUT_CYCLES, 2000000: maximum cycles between device clock falling edges, and also the final-release wait (20 ms at 100 MHz).

Ports:
- clock  in  1  system clock
- rst  in  1  asynchronous active-high reset
- tx_data  in  8  byte to send
- tx_start  in  1  request; sampled only in IDLE
- tx_busy  out  1  high from the cycle after acceptance until return to IDLE
- tx_done  out  1  one-cycle pulse: byte sent and ACK received (data sampled low)
- tx_err  out  1  one-cycle pulse: NACK or timeout
- ps2_clk_in  in  1  raw PS2_CLK pad level
- ps2_data_in  in  1  raw PS2_DATA pad level
- ps2_clk_drive_low  out  1  1 = pull PS2_CLK low
- ps2_data_drive_low  out  1  1 = pull PS2_DATA low

Behaviour:
Reset (asynchronous, active-high):
- All outputs are 0: both lines released, not busy, no pulses.
- State goes to IDLE and all counters clear.
- Reset asserted mid-transfer releases both lines immediately.

Input conditioning:
- ps2_clk_in and ps2_data_in each pass through a 2-flop synchronizer.
- fall = synchronized clock was 1 last cycle and is 0 now.
- Edge latency is 2-3 clock cycles.

Frame and parity:
- Frame is start(0), data bits 0..7 LSB first, parity, stop(1).
- Parity is odd: parity = ~^tx_data. It is computed from the byte latched at acceptance.

State machine:
- IDLE
  - Lines released.
  - If tx_start: latch tx_data, compute parity, assert tx_busy, go to INHIBIT.
- INHIBIT
  - clk_drive_low=1 for INHIBIT_CYCLES cycles.
  - Then assert data_drive_low=1 while keeping clk low for 1 cycle.
  - Then release clk and go to XFER with slot=0.
- XFER (data stays driven low as the start bit)
  - On each fall, slot increments.
  - slot 1..8: data_drive_low = ~bit[slot-1].
  - slot 9: data_drive_low = ~parity.
  - slot 10: data released (stop bit = 1).
  - After slot 10, go to ACK.
- ACK
  - On the next fall, sample synchronized data.
  - 0 → ack_ok, go to RELEASE. 1 → NACK, go to ERR.
- RELEASE
  - Wait until synchronized clk=1 and data=1.
  - Then pulse tx_done, go to IDLE.
- ERR
  - Pulse tx_err, release both lines, go to IDLE.

Timeout:
- Counter clears on each fall and on entry to XFER.
- It counts in XFER, ACK and RELEASE.
- Reaching TIMEOUT_CYCLES → ERR.

Boundary rules:
- tx_start while busy is ignored. No queueing.
- tx_done and tx_err are never asserted in the same cycle.
- tx_busy deasserts in the cycle after the done/err pulse, i.e. when back in IDLE.
- A fall during INHIBIT is ignored, because the host owns the clock then.
- A clock already held low by the device at request time does not matter: the inhibit overrides it.
- The line-drive outputs are registered. They change only on the cycle after the triggering fall is detected.
- Receive-path interaction: the device echoes 0xFA after ACK. That byte is handled by the receive path, not this block.

Test Plan:
1. Send 0xED (INHIBIT_CYCLES=20 for sim); device model clocks 11 slots and ACKs low.
   - Required: clk held low exactly 20 cycles.
   - Required: device samples on rising edges 0,1,0,1,1,0,1,1,1 (start, LSB-first data, parity=1), then stop=1.
   - Required: tx_done single pulse, tx_busy low after.
2. Send 0xF4.
   - Required: sampled parity 0.
   - Required: data slots 0,0,1,0,1,1,1,1.
   - Required: tx_done.
3. Send 0x00, device leaves data high in ACK slot.
   - Required: parity=1 sampled.
   - Required: tx_err one pulse, no tx_done, both drive_low=0 afterwards.
4. Device stops clocking after slot 4 (TIMEOUT_CYCLES=500).
   - Required: tx_err exactly 500 cycles after the last detected fall.
   - Required: lines released, tx_busy=0.
5. tx_start pulsed again during XFER with tx_data=0xFF.
   - Required: ignored; original byte completes.
   - Required: a following request for 0xFF after IDLE sends parity 1.
6. rst asserted during slot 6.
   - Required: drive_low outputs, tx_busy, tx_done and tx_err all 0 in the same cycle, no tx_done.
   - Required: after rst release, a new 0xED transfer succeeds.
